// File: rtl/wifi_uart_rx_buffer.sv
// UART receiver (16x oversampled, 8N1) feeding a FWFT byte FIFO with RTS flow control and LF count.
// Define WIFI_RX_PARITY_EN to switch the framing to 8E1 with a sticky parity_err flag.
module wifi_uart_rx_buffer #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned RTS_THRESH = 48
) (
    input  logic                          CLK_50M,
    input  logic                          reset,
    input  logic                          uart_rxd,
    output logic                          uart_rts_n,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    line_cnt,
    output logic                          framing_err,
    output logic                          overrun_err,
    output logic                          parity_err,
    input  logic                          err_clr
);

    localparam int unsigned DIV = CLK_HZ / (BAUD * 16);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = AW + 1;

    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_HI   = LW'(RTS_THRESH);
    localparam logic [LW-1:0] LVL_LO   = LW'(RTS_THRESH - 8);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StStop   = 3'd4;
    localparam logic [2:0] StBreak  = 3'd5;
`ifdef WIFI_RX_PARITY_EN
    localparam logic [2:0] StParity = 3'd3;
`endif

    logic          rx_meta_q, rxs_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tick, push, fe_set;

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= uart_rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    assign tick = (div_cnt_q == DIV_LAST);

`ifdef WIFI_RX_PARITY_EN
    logic par_q, par_d, pe_set, par_ok;
    assign par_ok = ~(^{shift_q, par_q});
`else
    logic par_ok;
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
        tick_cnt_d = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        push       = 1'b0;
        fe_set     = 1'b0;
`ifdef WIFI_RX_PARITY_EN
        par_d      = par_q;
        pe_set     = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (!rxs_q) begin
                    state_d    = StStart;
                    div_cnt_d  = '0;
                    tick_cnt_d = 4'd0;
                end
            end
            StStart: begin
                // Mid start bit: a high line here was only a glitch.
                if (tick && tick_cnt_q == 4'd7) begin
                    tick_cnt_d = 4'd0;
                    bit_idx_d  = 3'd0;
                    state_d    = rxs_q ? StIdle : StData;
                end
            end
            StData: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef WIFI_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef WIFI_RX_PARITY_EN
            StParity: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    par_d   = rxs_q;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    if (rxs_q) begin
                        state_d = StIdle;
                        push    = par_ok;
`ifdef WIFI_RX_PARITY_EN
                        pe_set  = ~par_ok;
`endif
                    end else begin
                        fe_set  = 1'b1;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rxs_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state_q    <= StIdle;
            div_cnt_q  <= '0;
            tick_cnt_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

`ifdef WIFI_RX_PARITY_EN
    logic parity_err_q;
    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= pe_set | (parity_err_q & ~err_clr);
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    line_q;
    logic          rts_q, framing_q, overrun_q;
    logic          full, do_pop, do_push, ovr_set, nl_in, nl_out;

    assign rd_valid = (level_q != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr_q] : 8'h00;
    assign full     = (level_q == LVL_FULL);
    assign do_pop   = rd_ready & rd_valid;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign do_push  = push & (~full | do_pop);
    assign ovr_set  = push & full & ~do_pop;
    assign nl_in    = do_push & (shift_q == 8'h0A);
    assign nl_out   = do_pop & (rd_data == 8'h0A);

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) level_d = level_q + 1'b1;
        else if (!do_push && do_pop) level_d = level_q - 1'b1;
    end

    always_ff @(posedge CLK_50M) begin
        if (do_push) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            line_q    <= 8'h00;
            rts_q     <= 1'b1;
            framing_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            if (nl_in && !nl_out && line_q != 8'hFF) line_q <= line_q + 8'd1;
            else if (nl_out && !nl_in && line_q != 8'h00) line_q <= line_q - 8'd1;
            // Hysteresis band keeps RTS from chattering around the threshold.
            if (level_d >= LVL_HI) rts_q <= 1'b1;
            else if (level_d <= LVL_LO) rts_q <= 1'b0;
            framing_q <= fe_set | (framing_q & ~err_clr);
            overrun_q <= ovr_set | (overrun_q & ~err_clr);
        end
    end

    assign fifo_level  = level_q;
    assign line_cnt    = line_q;
    assign uart_rts_n  = rts_q;
    assign framing_err = framing_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_wifi_uart_rx_buffer.sv
// Directed bench for wifi_uart_rx_buffer; BAUD scaled so DIV=3 (48-cycle bit) to keep runtime short.
module tb_wifi_uart_rx_buffer;

    localparam int BIT      = 48;
    localparam int STOP_POP = 26;

    logic       clk = 1'b0;
    logic       reset, uart_rxd, rd_ready, err_clr;
    logic       uart_rts_n, rd_valid, framing_err, overrun_err, parity_err;
    logic [7:0] rd_data, line_cnt;
    logic [6:0] fifo_level;
    int         total = 0;
    int         bad = 0;

    always #10 clk = ~clk;

    wifi_uart_rx_buffer #(
        .CLK_HZ(50000000),
        .BAUD(1041666),
        .FIFO_DEPTH(64),
        .RTS_THRESH(48)
    ) dut (
        .CLK_50M(clk),
        .reset(reset),
        .uart_rxd(uart_rxd),
        .uart_rts_n(uart_rts_n),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .fifo_level(fifo_level),
        .line_cnt(line_cnt),
        .framing_err(framing_err),
        .overrun_err(overrun_err),
        .parity_err(parity_err),
        .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        uart_rxd = v;
        repeat (n) @(negedge clk);
    endtask

    // pop_at >= 0 raises rd_ready for the single cycle whose edge samples the stop bit.
    task automatic send_frame(input logic [7:0] b, input int stop_low, input logic bad_par,
                              input int pop_at);
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
`ifdef WIFI_RX_PARITY_EN
        drive_bit((^b) ^ bad_par, BIT);
`else
        if (bad_par) drive_bit(1'b1, 0);
`endif
        if (stop_low > 0) begin
            drive_bit(1'b0, stop_low * BIT);
            drive_bit(1'b1, BIT);
        end else if (pop_at >= 0) begin
            uart_rxd = 1'b1;
            repeat (pop_at) @(negedge clk);
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
            repeat (BIT - pop_at - 1) @(negedge clk);
        end else begin
            drive_bit(1'b1, BIT);
        end
    endtask

    task automatic pop();
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] ok_str [4];
        ok_str = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
        uart_rxd = 1'b1;
        rd_ready = 1'b0;
        err_clr  = 1'b0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_data", rd_data, 8'h00);
        check("rst_level", fifo_level, 7'd0);
        check("rst_lines", line_cnt, 8'd0);
        check("rst_flags", {framing_err, overrun_err, parity_err}, 3'b000);
        check("rst_rts", uart_rts_n, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("rts_after_rst", uart_rts_n, 1'b0);
        repeat (10) @(negedge clk);

        send_frame(8'h41, 0, 1'b0, -1);
        check("single_valid", rd_valid, 1'b1);
        check("single_data", rd_data, 8'h41);
        check("single_level", fifo_level, 7'd1);
        check("single_flags", {framing_err, overrun_err, parity_err}, 3'b000);
        pop();
        check("single_pop_valid", rd_valid, 1'b0);
        check("single_pop_level", fifo_level, 7'd0);
        pop();
        check("empty_pop_level", fifo_level, 7'd0);

        for (int i = 0; i < 4; i++) send_frame(ok_str[i], 0, 1'b0, -1);
        check("ok_level", fifo_level, 7'd4);
        check("ok_lines", line_cnt, 8'd1);
        check("ok_head", rd_data, 8'h4F);
        for (int i = 0; i < 3; i++) pop();
        check("ok_lines_3pop", line_cnt, 8'd1);
        check("ok_head_lf", rd_data, 8'h0A);
        pop();
        check("ok_lines_4pop", line_cnt, 8'd0);
        check("ok_level_4pop", fifo_level, 7'd0);

        for (int i = 0; i < 70; i++) begin
            b = 8'h20 + 8'(i);
            send_frame(b, 0, 1'b0, -1);
            if (i == 46) check("rts_at_47", uart_rts_n, 1'b0);
            if (i == 47) check("rts_at_48", uart_rts_n, 1'b1);
            if (i == 63) check("ovr_not_yet", overrun_err, 1'b0);
        end
        check("full_level", fifo_level, 7'd64);
        check("full_overrun", overrun_err, 1'b1);
        check("full_head", rd_data, 8'h20);
        check("full_lines", line_cnt, 8'd0);
        for (int i = 0; i < 23; i++) pop();
        check("rts_hold_41", uart_rts_n, 1'b1);
        pop();
        check("rts_drop_40", uart_rts_n, 1'b0);
        check("head_after_24", rd_data, 8'h38);
        pulse_clr();
        check("overrun_clr", overrun_err, 1'b0);

        for (int i = 0; i < 24; i++) begin
            b = 8'h60 + 8'(i);
            send_frame(b, 0, 1'b0, -1);
        end
        check("refill_level", fifo_level, 7'd64);
        send_frame(8'h99, 0, 1'b0, STOP_POP);
        check("simul_level", fifo_level, 7'd64);
        check("simul_overrun", overrun_err, 1'b0);
        check("simul_head", rd_data, 8'h39);
        for (int i = 0; i < 63; i++) pop();
        check("simul_tail_level", fifo_level, 7'd1);
        check("simul_tail_data", rd_data, 8'h99);
        pop();
        check("drain_valid", rd_valid, 1'b0);

        send_frame(8'h55, 2, 1'b0, -1);
        check("framing_set", framing_err, 1'b1);
        check("framing_level", fifo_level, 7'd0);
        pulse_clr();
        check("framing_clr", framing_err, 1'b0);
        drive_bit(1'b0, 10);
        drive_bit(1'b1, BIT * 11);
        check("glitch_flag", framing_err, 1'b0);
        check("glitch_level", fifo_level, 7'd0);

        send_frame(8'h0A, 0, 1'b0, -1);
        check("pre_rst_lines", line_cnt, 8'd1);
        b = 8'h3C;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_bit(b[i], BIT);
        drive_bit(b[4], BIT / 2);
        reset    = 1'b1;
        uart_rxd = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_valid", rd_valid, 1'b0);
        check("midrst_level", fifo_level, 7'd0);
        check("midrst_lines", line_cnt, 8'd0);
        check("midrst_rts", uart_rts_n, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_rts_drop", uart_rts_n, 1'b0);
        repeat (BIT * 12) @(negedge clk);
        check("midrst_no_push", fifo_level, 7'd0);
        send_frame(8'h7E, 0, 1'b0, -1);
        check("after_rst_data", rd_data, 8'h7E);
        check("after_rst_level", fifo_level, 7'd1);
        check("after_rst_flags", {framing_err, overrun_err}, 2'b00);
        pop();
`ifdef WIFI_RX_PARITY_EN
        send_frame(8'h7E, 0, 1'b1, -1);
        check("parity_set", parity_err, 1'b1);
        check("parity_level", fifo_level, 7'd0);
`else
        check("parity_tied", parity_err, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
